// File: rtl/alu_mc.sv
// alu_mc: multi-cycle 8051 ALU with a start/busy/done handshake.
// Single-cycle ops finish one edge after start. MUL (shift-add) and DIV
// (restoring) iterate WIDTH times and return both result halves.
// Optional feature macro ALU_MC_DIV_EN: when defined, the iterative divider
// is built; when undefined, op 6 finishes in one cycle with zero results
// and OV set.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [SEL_W-1:0] bit_sel,
  input  logic [7:0]       psw_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_hi,
  output logic [7:0]       psw_out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_SUBB = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_DIV  = 4'd6;
  localparam logic [3:0] OP_ANL  = 4'd7;
  localparam logic [3:0] OP_ORL  = 4'd8;
  localparam logic [3:0] OP_XRL  = 4'd9;
  localparam logic [3:0] OP_SETB = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;
  localparam logic [3:0] OP_CPLA = 4'd12;
  localparam logic [3:0] OP_MOV  = 4'd13;
  localparam logic [3:0] OP_CPLB = 4'd14;
  localparam logic [3:0] OP_RSV  = 4'd15;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [SEL_W-1:0] CNT_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] CNT_INIT = SEL_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SEL_W-1:0] sel_q;
  logic [7:0]       psw_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [SEL_W-1:0] cnt_q;

  logic             iter_op;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             cin;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic [7:0]       psw_next;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  // Decide whether the op being requested needs the iterative datapath.
  always_comb begin
    iter_op = (alu_op == OP_MUL);
`ifdef ALU_MC_DIV_EN
    if ((alu_op == OP_DIV) && (b_data != '0)) iter_op = 1'b1;
`endif
  end

  // One iteration of shift-add multiply or restoring divide on {hi_q, lo_q}.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    div_ge    = (div_shift >= {1'b0, b_q});
    if (op_q == OP_DIV) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  // Final result and PSW from the latched operands; carries into bit 4 and
  // into the MSB are recovered as a^b^sum at that bit position.
  always_comb begin
    res      = '0;
    res_hi   = '0;
    psw_next = psw_q;
    cin      = ((op_q == OP_ADDC) || (op_q == OP_SUBB)) ? psw_q[7] : 1'b0;
    add_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    sub_full = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
    bit_mask = ONE << sel_q;
    case (op_q)
      OP_ADD, OP_ADDC: begin
        res         = add_full[WIDTH-1:0];
        psw_next[7] = add_full[WIDTH];
        psw_next[6] = a_q[4] ^ b_q[4] ^ add_full[4];
        psw_next[2] = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_full[WIDTH-1] ^ add_full[WIDTH];
      end
      OP_SUBB: begin
        res         = sub_full[WIDTH-1:0];
        psw_next[7] = sub_full[WIDTH];
        psw_next[6] = a_q[4] ^ b_q[4] ^ sub_full[4];
        psw_next[2] = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sub_full[WIDTH-1] ^ sub_full[WIDTH];
      end
      OP_INC:  res = a_q + ONE;
      OP_DEC:  res = a_q - ONE;
      OP_MUL: begin
        res         = lo_q;
        res_hi      = hi_q;
        psw_next[7] = 1'b0;
        psw_next[2] = |hi_q;
      end
      OP_DIV: begin
        psw_next[7] = 1'b0;
`ifdef ALU_MC_DIV_EN
        if (b_q == '0) begin
          res         = '1;
          res_hi      = a_q;
          psw_next[2] = 1'b1;
        end else begin
          res         = lo_q;
          res_hi      = hi_q;
          psw_next[2] = 1'b0;
        end
`else
        psw_next[2] = 1'b1;
`endif
      end
      OP_ANL:  res = a_q & b_q;
      OP_ORL:  res = a_q | b_q;
      OP_XRL:  res = a_q ^ b_q;
      OP_SETB: res = a_q | bit_mask;
      OP_CLR:  res = a_q & ~bit_mask;
      OP_CPLA: res = ~a_q;
      OP_MOV:  res = b_q;
      OP_CPLB: res = a_q ^ bit_mask;
      default: ;
    endcase
    if (op_q != OP_RSV) psw_next[0] = ^res;
  end

  // Handshake FSM: latch request, iterate if needed, publish results with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      psw_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ans     <= '0;
      ans_hi  <= '0;
      psw_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= alu_op;
            a_q   <= a_data;
            b_q   <= b_data;
            sel_q <= bit_sel;
            psw_q <= psw_in;
            hi_q  <= '0;
            lo_q  <= a_data;
            cnt_q <= CNT_INIT;
            busy  <= 1'b1;
            state <= iter_op ? CALC : DONE;
          end
        end
        CALC: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (cnt_q == '0) state <= DONE;
          else             cnt_q <= cnt_q - CNT_ONE;
        end
        DONE: begin
          ans     <= res;
          ans_hi  <= res_hi;
          psw_out <= psw_next;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=8 and WIDTH=16 instances).
// Directed vectors, a randomized run against a behavioural model, ignored
// start during MUL, reset mid-operation and the 16-bit multiply.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] alu_op;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic [2:0] bit_sel;
  logic [7:0] psw_in;
  logic       busy;
  logic       done;
  logic [7:0] ans;
  logic [7:0] ans_hi;
  logic [7:0] psw_out;

  logic        w_start;
  logic [3:0]  w_op;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [3:0]  w_sel;
  logic [7:0]  w_psw;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_ans;
  logic [15:0] w_hi;
  logic [7:0]  w_psw_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] psw;
    logic [7:0] e_ans;
    logic [7:0] e_hi;
    logic [7:0] e_psw;
    logic [7:0] e_lat;
  } vec_t;

  vec_t dir_vecs [12];

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
    .a_data(a_data), .b_data(b_data), .bit_sel(bit_sel), .psw_in(psw_in),
    .busy(busy), .done(done), .ans(ans), .ans_hi(ans_hi), .psw_out(psw_out)
  );

  alu_mc #(.WIDTH(16)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .alu_op(w_op),
    .a_data(w_a), .b_data(w_b), .bit_sel(w_sel), .psw_in(w_psw),
    .busy(w_busy), .done(w_done), .ans(w_ans), .ans_hi(w_hi), .psw_out(w_psw_out)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Overall time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Behavioural 8-bit reference: integer arithmetic on the op definitions
  function automatic void ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] sel, input logic [7:0] psw,
                                    output logic [7:0] e_ans, output logic [7:0] e_hi,
                                    output logic [7:0] e_psw, output int e_lat);
    int cin;
    int r;
    int sr;
    logic [7:0] mask;
    e_ans = 8'h00;
    e_hi  = 8'h00;
    e_psw = psw;
    e_lat = 1;
    mask  = 8'd1 << sel;
    cin   = ((op == 4'd1) || (op == 4'd4)) ? int'(psw[7]) : 0;
    case (op)
      4'd0, 4'd1: begin
        r  = int'(a) + int'(b) + cin;
        sr = int'($signed(a)) + int'($signed(b)) + cin;
        e_ans    = r[7:0];
        e_psw[7] = (r > 255);
        e_psw[6] = ((int'(a) % 16) + (int'(b) % 16) + cin) > 15;
        e_psw[2] = (sr > 127) || (sr < -128);
      end
      4'd4: begin
        r  = int'(a) - int'(b) - cin;
        sr = int'($signed(a)) - int'($signed(b)) - cin;
        e_ans    = r[7:0];
        e_psw[7] = (r < 0);
        e_psw[6] = ((int'(a) % 16) - (int'(b) % 16) - cin) < 0;
        e_psw[2] = (sr > 127) || (sr < -128);
      end
      4'd2: e_ans = a + 8'd1;
      4'd3: e_ans = a - 8'd1;
      4'd5: begin
        r = int'(a) * int'(b);
        e_ans    = 8'(r % 256);
        e_hi     = 8'(r / 256);
        e_psw[7] = 1'b0;
        e_psw[2] = (e_hi != 8'h00);
        e_lat    = 9;
      end
      4'd6: begin
        e_psw[7] = 1'b0;
`ifdef ALU_MC_DIV_EN
        if (b == 8'h00) begin
          e_ans    = 8'hFF;
          e_hi     = a;
          e_psw[2] = 1'b1;
        end else begin
          e_ans    = a / b;
          e_hi     = a % b;
          e_psw[2] = 1'b0;
          e_lat    = 9;
        end
`else
        e_psw[2] = 1'b1;
`endif
      end
      4'd7:  e_ans = a & b;
      4'd8:  e_ans = a | b;
      4'd9:  e_ans = a ^ b;
      4'd10: e_ans = a | mask;
      4'd11: e_ans = a & ~mask;
      4'd12: e_ans = ~a;
      4'd13: e_ans = b;
      4'd14: e_ans = a ^ mask;
      default: ;
    endcase
    if (op != 4'd15) e_psw[0] = ^e_ans;
  endfunction

  // Issue one request on the 8-bit DUT; report latency (edges after the
  // start edge until done) and busy-high samples. Inputs are scrambled after
  // the start edge so results must come from latched operands.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel, input logic [7:0] psw, input bit poke,
                        output int lat, output int bcnt);
    @(negedge clk);
    alu_op = op; a_data = a; b_data = b; bit_sel = sel; psw_in = psw; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    lat    = -1;
    bcnt   = busy ? 1 : 0;
    alu_op = 4'd13; a_data = ~a; b_data = ~b; psw_in = ~psw;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
      if (poke && i == 3) start = 1'b1;
      if (poke && i == 4) start = 1'b0;
    end
  endtask

  // Outputs are zero while reset is held and stay idle after release
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alu_op = 4'd0; a_data = 8'h00; b_data = 8'h00;
    bit_sel = 3'd0; psw_in = 8'h00;
    w_start = 1'b0; w_op = 4'd0; w_a = 16'h0; w_b = 16'h0; w_sel = 4'd0; w_psw = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    checks++; if (ans !== 8'h00)      begin errors++; $display("[TB] FAIL reset ans: got %h expected 00", ans); end
    checks++; if (ans_hi !== 8'h00)   begin errors++; $display("[TB] FAIL reset ans_hi: got %h expected 00", ans_hi); end
    checks++; if (psw_out !== 8'h00)  begin errors++; $display("[TB] FAIL reset psw_out: got %h expected 00", psw_out); end
    checks++; if (w_ans !== 16'h0000) begin errors++; $display("[TB] FAIL reset w_ans: got %h expected 0000", w_ans); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL idle busy/done: got %b/%b expected 0/0", busy, done);
    end
  endtask

  // Hand-computed vectors from the op definitions, including wrap cases
  task automatic test_directed();
    int lat;
    int bcnt;
    dir_vecs[0]  = '{4'd0,  8'h7F, 8'h01, 3'd0, 8'h00, 8'h80, 8'h00, 8'h45, 8'd1};
    dir_vecs[1]  = '{4'd4,  8'h00, 8'h01, 3'd0, 8'h80, 8'hFE, 8'h00, 8'hC1, 8'd1};
    dir_vecs[2]  = '{4'd5,  8'h50, 8'hA0, 3'd0, 8'h00, 8'h00, 8'h32, 8'h04, 8'd9};
`ifdef ALU_MC_DIV_EN
    dir_vecs[3]  = '{4'd6,  8'hFB, 8'h12, 3'd0, 8'h00, 8'h0D, 8'h11, 8'h01, 8'd9};
    dir_vecs[4]  = '{4'd6,  8'hFB, 8'h00, 3'd0, 8'h80, 8'hFF, 8'hFB, 8'h04, 8'd1};
`else
    dir_vecs[3]  = '{4'd6,  8'hFB, 8'h12, 3'd0, 8'h00, 8'h00, 8'h00, 8'h04, 8'd1};
    dir_vecs[4]  = '{4'd6,  8'hFB, 8'h00, 3'd0, 8'h80, 8'h00, 8'h00, 8'h04, 8'd1};
`endif
    dir_vecs[5]  = '{4'd14, 8'h0F, 8'h00, 3'd7, 8'h00, 8'h8F, 8'h00, 8'h01, 8'd1};
    dir_vecs[6]  = '{4'd10, 8'h00, 8'h00, 3'd0, 8'h00, 8'h01, 8'h00, 8'h01, 8'd1};
    dir_vecs[7]  = '{4'd15, 8'h33, 8'h44, 3'd2, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'd1};
    dir_vecs[8]  = '{4'd2,  8'hFF, 8'h00, 3'd0, 8'hC4, 8'h00, 8'h00, 8'hC4, 8'd1};
    dir_vecs[9]  = '{4'd3,  8'h00, 8'h00, 3'd0, 8'hC4, 8'hFF, 8'h00, 8'hC4, 8'd1};
    dir_vecs[10] = '{4'd1,  8'hFF, 8'h00, 3'd0, 8'h80, 8'h00, 8'h00, 8'hC0, 8'd1};
    dir_vecs[11] = '{4'd11, 8'hFF, 8'h00, 3'd3, 8'h00, 8'hF7, 8'h00, 8'h01, 8'd1};
    for (int i = 0; i < 12; i++) begin
      run_op(dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].sel, dir_vecs[i].psw, 1'b0, lat, bcnt);
      checks++; if (ans !== dir_vecs[i].e_ans) begin
        errors++; $display("[TB] FAIL dir[%0d] ans: got %h expected %h", i, ans, dir_vecs[i].e_ans);
      end
      checks++; if (ans_hi !== dir_vecs[i].e_hi) begin
        errors++; $display("[TB] FAIL dir[%0d] ans_hi: got %h expected %h", i, ans_hi, dir_vecs[i].e_hi);
      end
      checks++; if (psw_out !== dir_vecs[i].e_psw) begin
        errors++; $display("[TB] FAIL dir[%0d] psw_out: got %h expected %h", i, psw_out, dir_vecs[i].e_psw);
      end
      checks++; if (lat != int'(dir_vecs[i].e_lat)) begin
        errors++; $display("[TB] FAIL dir[%0d] latency: got %0d expected %0d", i, lat, dir_vecs[i].e_lat);
      end
      checks++; if (bcnt != int'(dir_vecs[i].e_lat) || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL dir[%0d] busy: got %0d cycles (now %b) expected %0d (now 0)", i, bcnt, busy, dir_vecs[i].e_lat);
      end
    end
  endtask

  // MUL with a start pulse mid-operation: no effect, no second done, results hold
  task automatic test_ignore_start();
    int lat;
    int bcnt;
    int extra;
    run_op(4'd5, 8'h50, 8'hA0, 3'd0, 8'h00, 1'b1, lat, bcnt);
    checks++; if (ans !== 8'h00 || ans_hi !== 8'h32) begin
      errors++; $display("[TB] FAIL ignore mul result: got %h_%h expected 32_00", ans_hi, ans);
    end
    checks++; if (lat != 9) begin errors++; $display("[TB] FAIL ignore mul latency: got %0d expected 9", lat); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("[TB] FAIL ignore extra done: got %0d expected 0", extra); end
    checks++; if (ans_hi !== 8'h32 || psw_out !== 8'h04) begin
      errors++; $display("[TB] FAIL hold outputs: got %h/%h expected 32/04", ans_hi, psw_out);
    end
  endtask

  // Randomized requests compared with the reference model
  task automatic test_random();
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] psw;
    logic [7:0] e_ans;
    logic [7:0] e_hi;
    logic [7:0] e_psw;
    int e_lat;
    int lat;
    int bcnt;
    for (int n = 0; n < 60; n++) begin
      op  = 4'($urandom_range(0, 15));
      a   = 8'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sel = 3'($urandom);
      psw = 8'($urandom);
      ref_model(op, a, b, sel, psw, e_ans, e_hi, e_psw, e_lat);
      run_op(op, a, b, sel, psw, 1'b0, lat, bcnt);
      checks++; if (ans !== e_ans || ans_hi !== e_hi) begin
        errors++; $display("[TB] FAIL rnd[%0d] op%0d a=%h b=%h: got %h_%h expected %h_%h", n, op, a, b, ans_hi, ans, e_hi, e_ans);
      end
      checks++; if (psw_out !== e_psw) begin
        errors++; $display("[TB] FAIL rnd[%0d] op%0d psw: got %h expected %h", n, op, psw_out, e_psw);
      end
      checks++; if (lat != e_lat || bcnt != e_lat) begin
        errors++; $display("[TB] FAIL rnd[%0d] op%0d timing: got lat %0d busy %0d expected %0d", n, op, lat, bcnt, e_lat);
      end
    end
  endtask

  // Reset three cycles into MUL clears everything at once; later ops run normally
  task automatic test_reset_mid();
    int lat;
    int bcnt;
    int seen;
    @(negedge clk);
    alu_op = 4'd5; a_data = 8'h50; b_data = 8'hA0; bit_sel = 3'd0; psw_in = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset busy/done: got %b/%b expected 0/0", busy, done);
    end
    checks++; if (ans !== 8'h00 || ans_hi !== 8'h00 || psw_out !== 8'h00) begin
      errors++; $display("[TB] FAIL midreset outputs: got %h/%h/%h expected 00/00/00", ans, ans_hi, psw_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midreset aborted op resumed: got %0d active cycles expected 0", seen); end
    run_op(4'd0, 8'h12, 8'h34, 3'd0, 8'h00, 1'b0, lat, bcnt);
    checks++; if (ans !== 8'h46 || psw_out !== 8'h01 || lat != 1) begin
      errors++; $display("[TB] FAIL post-reset add: got %h psw %h lat %0d expected 46 psw 01 lat 1", ans, psw_out, lat);
    end
    run_op(4'd5, 8'h0F, 8'h11, 3'd0, 8'h00, 1'b0, lat, bcnt);
    checks++; if (ans !== 8'hFF || ans_hi !== 8'h00 || psw_out !== 8'h00 || lat != 9) begin
      errors++; $display("[TB] FAIL post-reset mul: got %h_%h psw %h lat %0d expected 00_FF psw 00 lat 9", ans_hi, ans, psw_out, lat);
    end
  endtask

  // 16-bit instance: full-scale MUL and a signed-overflow ADD
  task automatic test_wide();
    int lat;
    @(negedge clk);
    w_op = 4'd5; w_a = 16'hFFFF; w_b = 16'hFFFF; w_sel = 4'd0; w_psw = 8'h00; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (w_done) begin
        lat = i;
        break;
      end
    end
    checks++; if (w_ans !== 16'h0001 || w_hi !== 16'hFFFE) begin
      errors++; $display("[TB] FAIL wide mul: got %h_%h expected FFFE_0001", w_hi, w_ans);
    end
    checks++; if (w_psw_out !== 8'h05) begin errors++; $display("[TB] FAIL wide mul psw: got %h expected 05", w_psw_out); end
    checks++; if (lat != 17) begin errors++; $display("[TB] FAIL wide mul latency: got %0d expected 17", lat); end
    @(negedge clk);
    w_op = 4'd0; w_a = 16'h7FFF; w_b = 16'h0001; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (w_done) begin
        lat = i;
        break;
      end
    end
    checks++; if (w_ans !== 16'h8000 || w_hi !== 16'h0000 || w_psw_out !== 8'h45 || lat != 1) begin
      errors++; $display("[TB] FAIL wide add: got %h hi %h psw %h lat %0d expected 8000 hi 0000 psw 45 lat 1", w_ans, w_hi, w_psw_out, lat);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_random();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
